mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit; consumes the 4-bit MDU operation code from the instruction decoder together with rs/rt operand values.
- Owns the architectural HI/LO registers and models multi-cycle latency: mult/multu take 5 cycles, div/divu take 10.
- Exports start/busy so the hazard unit stalls D-stage md/mf/mt instructions while an operation is in flight.
- mfhi/mflo read data leaves through MDOut into the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  E-stage instruction valid (low for bubble/flush); gates all ops
MDUControl  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
A  input  32  rs operand (dividend / multiplicand / mt source)
B  input  32  rt operand (divisor / multiplier)
start  output  1  combinational; high in the issue cycle of an accepted md op
busy  output  1  registered; high while an md op is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDOut  output  32  combinational; HI if op=5, LO if op=6, else 0

Behaviour:
- Reset: busy=0, counter=0, HI=0, LO=0, pending result cleared. start and MDOut follow their combinational definitions.
- Reset mid-operation discards the pending result; the next cycle shows busy=0 and HI=LO=0.
- Accept rule: md op (codes 1-4) is accepted when en=1 and busy=0; start=en & md & ~busy.
- Issue edge T0: latch the computed 64-bit result into pending_hi/pending_lo, load counter=N (MULT_CYCLES or DIV_CYCLES), set busy=1.
- In flight: each edge with busy=1 decrements the counter. On the edge where counter==1: HI/LO <= pending, busy <= 0.
- Net timing: busy is high exactly N cycles after the issue cycle. HI/LO change on the same edge busy falls.
- Read timing: mfhi/mflo in the first cycle with busy=0 sees the new value.
- HI/LO are not visible early: reads during busy return old values. The hazard unit prevents this; the unit does not need to.
- mult: signed 32x32 -> 64, {HI,LO}=product.
- multu: unsigned 32x32 -> 64, {HI,LO}=product.
- div/divu: LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (B==0): full busy period still runs; HI/LO keep prior values (pending loads current HI/LO).
- mthi/mtlo: accepted when en=1 and busy=0; HI or LO <= A on the next edge; no busy.
- Any op (1-4, 7, 8) presented while busy=1 is ignored (no state change). The bench flags this as a hazard-unit violation.
- en=0: no state change except the in-flight countdown, which continues regardless of en.
- Simultaneous reset and issue: reset wins.
- Codes 0 and 9-15: no effect; MDOut=0.

Decomposition:
- Shared package: MDU op encodings (MDU_NONE..MDU_MTLO, values 0-8), MULT_CYCLES/DIV_CYCLES defaults, and an is_md helper predicate (codes 1-4). The decoder and hazard unit use the same package.
- One sub-module, mdu_arith: purely combinational. Inputs op, A, B, cur_hi, cur_lo; outputs res_hi, res_lo. Covers signed/unsigned mult, div, div-by-zero hold and the overflow case.
- mul_div_unit holds the counter, busy, pending and HI/LO registers, and the accept logic.

Test Plan:
- Reset held 2 cycles, then released → HI=LO=0, busy=0, MDOut=0 for op=5 and op=6.
- mult, A=0xFFFFFFFE, B=3 → start=1 in the issue cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/2 → LO=3, HI=1.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload via mthi 0x1234 and mtlo 0x5678 (each visible the next cycle via MDOut with op=5/6), then div with B=0 → busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- During a mult busy period, present mthi A=0xDEAD and a second mult → both ignored: HI is not 0xDEAD, busy count is not extended, start=0.
- Start div, assert reset on the 4th busy cycle → next cycle busy=0, HI=LO=0; after release, mflo reads 0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
// Shared definitions for the execute-stage multiply/divide unit. The decoder
// and hazard unit import this package too, so the op encodings live here once.
//   mdu_op_e        : 4-bit MDU operation codes (0..8, all others are no-ops)
//   MDU_MULT_CYCLES : default busy length of mult/multu
//   MDU_DIV_CYCLES  : default busy length of div/divu
//   is_md()         : true for the multi-cycle ops (mult, multu, div, divu)
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_md(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
// Purely combinational result generator for the multiply/divide unit. The
// 64-bit {res_hi, res_lo} is what HI/LO will hold once the busy period ends.
//   op             : MDU operation code (mdu_op_e encoding)
//   A, B           : rs / rt operands
//   cur_hi, cur_lo : current architectural HI/LO (returned for div-by-zero
//                    and for every non-arithmetic op)
//   res_hi, res_lo : resulting HI/LO
module mdu_arith
    import mul_div_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
    logic               neg_a;
    logic               neg_b;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        safe_b;
    logic [31:0]        safe_abs_b;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        u_q;
    logic [31:0]        u_r;

    assign s_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign u_prod = {32'd0, A} * {32'd0, B};

    // Signed division is done on magnitudes and the signs are reapplied, which
    // gives truncation toward zero and a remainder signed like the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, sign positive.
    assign neg_a = A[31];
    assign neg_b = B[31];
    assign abs_a = neg_a ? (32'd0 - A) : A;
    assign abs_b = neg_b ? (32'd0 - B) : B;

    // Divisors forced non-zero so the dividers never see x; the zero case is
    // overridden below anyway.
    assign safe_b     = (B == 32'd0) ? 32'd1 : B;
    assign safe_abs_b = (B == 32'd0) ? 32'd1 : abs_b;

    assign mag_q = abs_a / safe_abs_b;
    assign mag_r = abs_a % safe_abs_b;
    assign u_q   = A / safe_b;
    assign u_r   = A % safe_b;

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MDU_MULT: begin
                res_hi = s_prod[63:32];
                res_lo = s_prod[31:0];
            end
            MDU_MULTU: begin
                res_hi = u_prod[63:32];
                res_lo = u_prod[31:0];
            end
            MDU_DIV: begin
                if (B != 32'd0) begin
                    res_lo = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
                    res_hi = neg_a ? (32'd0 - mag_r) : mag_r;
                end
            end
            MDU_DIVU: begin
                if (B != 32'd0) begin
                    res_lo = u_q;
                    res_hi = u_r;
                end
            end
            default: begin
                res_hi = cur_hi;
                res_lo = cur_lo;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Execute-stage multiply/divide unit. Owns HI/LO and models multi-cycle
// latency: the result is computed at issue, parked in pending registers, and
// committed to HI/LO on the edge where busy falls.
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   en         : E-stage instruction valid; gates every op
//   MDUControl : operation code (mdu_op_e)
//   A, B       : rs / rt operands
//   start      : high in the issue cycle of an accepted mult/div
//   busy       : high while a mult/div is in flight
//   HI, LO     : architectural HI/LO registers
//   MDOut      : HI for mfhi, LO for mflo, otherwise 0
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  MDUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    logic [CNT_W-1:0] counter;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             md;

    mdu_arith u_arith (
        .op     (MDUControl),
        .A      (A),
        .B      (B),
        .cur_hi (HI),
        .cur_lo (LO),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign md    = is_md(MDUControl);
    assign start = en & md & ~busy;

    always_comb begin
        MDOut = 32'd0;
        if (MDUControl == MDU_MFHI) begin
            MDOut = HI;
        end else if (MDUControl == MDU_MFLO) begin
            MDOut = LO;
        end
    end

    // While busy, the countdown runs regardless of en and every new op is
    // dropped; the edge that sees counter==1 commits pending into HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            counter    <= '0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else if (busy) begin
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                HI   <= pending_hi;
                LO   <= pending_lo;
                busy <= 1'b0;
            end
        end else if (en) begin
            if (md) begin
                pending_hi <= res_hi;
                pending_lo <= res_lo;
                counter    <= is_mult(MDUControl) ? CNT_W'(MULT_CYCLES)
                                                  : CNT_W'(DIV_CYCLES);
                busy       <= 1'b1;
            end else if (MDUControl == MDU_MTHI) begin
                HI <= A;
            end else if (MDUControl == MDU_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Directed testbench for mul_div_unit with hand-computed expected values.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  MDUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int testCount;
    int failCount;

    mul_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .MDUControl (MDUControl),
        .A          (A),
        .B          (B),
        .start      (start),
        .busy       (busy),
        .HI         (HI),
        .LO         (LO),
        .MDOut      (MDOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enIn, input logic [3:0] op,
                                 input logic [31:0] aIn, input logic [31:0] bIn);
        en         = enIn;
        MDUControl = op;
        A          = aIn;
        B          = bIn;
    endtask

    // Read HI and LO back through MDOut with mfhi/mflo (no clock edge used).
    task automatic checkReads(input string tag, input logic [31:0] expHi,
                              input logic [31:0] expLo);
        applyStimulus(1'b1, 4'd5, 32'd0, 32'd0);
        #1 checkOutput({tag, " mfhi"}, MDOut, expHi);
        applyStimulus(1'b1, 4'd6, 32'd0, 32'd0);
        #1 checkOutput({tag, " mflo"}, MDOut, expLo);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
    endtask

    // Issue one md op, count busy cycles, then check HI/LO in the first idle
    // cycle both directly and via mfhi/mflo.
    task automatic runMd(input string tag, input logic [3:0] op,
                         input logic [31:0] aIn, input logic [31:0] bIn,
                         input int cycles, input logic [31:0] expHi,
                         input logic [31:0] expLo);
        int cnt;
        @(negedge clk);
        applyStimulus(1'b1, op, aIn, bIn);
        #1 checkOutput({tag, " start"}, 32'(start), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput({tag, " busy cycles"}, 32'(cnt), 32'(cycles));
        checkOutput({tag, " HI"}, HI, expHi);
        checkOutput({tag, " LO"}, LO, expLo);
        checkReads(tag, expHi, expLo);
    endtask

    initial begin
        int cnt;
        testCount = 0;
        failCount = 0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);

        // Reset held for two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        checkReads("reset", 32'd0, 32'd0);

        // Arithmetic cases.
        runMd("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        runMd("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        runMd("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runMd("divu",  4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        runMd("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        // mthi/mtlo preload, each visible the following cycle.
        @(negedge clk);
        applyStimulus(1'b1, 4'd7, 32'h1234, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'd5, 32'd0, 32'd0);
        #1 checkOutput("mthi read", MDOut, 32'h1234);
        applyStimulus(1'b1, 4'd8, 32'h5678, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'd6, 32'd0, 32'd0);
        #1 checkOutput("mtlo read", MDOut, 32'h5678);

        // Divide by zero keeps HI/LO but still runs the full busy period.
        runMd("div0", 4'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

        // en=0 must block an mthi.
        @(negedge clk);
        applyStimulus(1'b0, 4'd7, 32'hBEEF, 32'd0);
        @(negedge clk);
        checkOutput("en0 HI", HI, 32'h1234);

        // Ops during busy are ignored: mthi and a second mult.
        @(negedge clk);
        applyStimulus(1'b1, 4'd1, 32'd3, 32'd4);
        @(negedge clk);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 1) begin
                applyStimulus(1'b1, 4'd7, 32'hDEAD, 32'd0);
                #1 checkOutput("hazard mthi start", 32'(start), 32'd0);
            end else if (cnt == 2) begin
                applyStimulus(1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
                #1 checkOutput("hazard mult start", 32'(start), 32'd0);
            end else begin
                applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
            end
            @(negedge clk);
        end
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        checkOutput("hazard busy cycles", 32'(cnt), 32'd5);
        checkOutput("hazard HI", HI, 32'd0);
        checkOutput("hazard LO", LO, 32'd12);
        @(negedge clk);
        checkOutput("hazard no reissue", 32'(busy), 32'd0);

        // Reset on the 4th busy cycle of a div discards the pending result.
        @(negedge clk);
        applyStimulus(1'b1, 4'd7, 32'h0000AAAA, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'd3, 32'd100, 32'd7);
        @(negedge clk);
        applyStimulus(1'b1, 4'd0, 32'd0, 32'd0);
        cnt = 1;
        while (busy === 1'b1 && cnt < 4) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("reset mid busy seen", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset mid busy", 32'(busy), 32'd0);
        checkOutput("reset mid HI", HI, 32'd0);
        checkOutput("reset mid LO", LO, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkReads("after reset", 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
